// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: opcodes, bubble instruction and fetch FSM encodings.
package fetch_unit_pkg;

    localparam int unsigned DEF_PC_W  = 16;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned ST_W      = 3;
    localparam int unsigned MISS_W    = 16;

    localparam logic [OPC_W-1:0]    DEF_HLT_OPC   = 4'hF;
    localparam logic [DEF_PC_W-1:0] DEF_NOP_INSTR = 16'h0000;
    localparam logic [DEF_PC_W-1:0] DEF_RESET_PC  = 16'h0000;

    localparam logic [ST_W-1:0] ST_RUN  = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd1;
    localparam logic [ST_W-1:0] ST_HOLD = 3'd2;
    localparam logic [ST_W-1:0] ST_DROP = 3'd3;
    localparam logic [ST_W-1:0] ST_HALT = 3'd4;

    // States in which a fetch request is on the imem interface
    function automatic logic fetch_active(input logic [ST_W-1:0] st);
        return (st == ST_RUN) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with load enable and asynchronous reset to RESET_PC.
module fetch_unit_pc_reg #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, tracks imem misses, applies branch redirects/stalls, halts on HLT.
// Optional FETCH_MISS_CNT_EN adds the miss_cycles counter output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      PC_W      = DEF_PC_W,
    parameter logic [PC_W-1:0]  RESET_PC  = DEF_RESET_PC,
    parameter logic [PC_W-1:0]  NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [OPC_W-1:0] HLT_OPC   = DEF_HLT_OPC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [PC_W-1:0] imem_instr,
    output logic            ifid_wen,
    output logic [PC_W-1:0] ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] pc,
    output logic            halted
`ifdef FETCH_MISS_CNT_EN
    ,
    output logic [MISS_W-1:0] miss_cycles
`endif
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_d;
    logic [PC_W-1:0] hold_buf;
    logic [PC_W-1:0] hold_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] acc_instr;
    logic            pc_en;
    logic            active;

    fetch_unit_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc)
    );

    // Request/halt decode comes from state only, so imem_instr never reaches imem_req/imem_addr
    assign active    = fetch_active(state);
    assign imem_req  = active;
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign pc_inc    = PC_W'(pc + PC_W'(2));
    assign acc_instr = (state == ST_HOLD) ? hold_buf : imem_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            hold_buf <= NOP_INSTR;
        end else begin
            state    <= state_d;
            hold_buf <= hold_d;
        end
    end

    // Next state, PC update and IF/ID write side; priority br_taken > stall > imem_valid
    always_comb begin
        state_d    = state;
        hold_d     = hold_buf;
        pc_en      = 1'b0;
        pc_d       = pc_inc;
        ifid_wen   = 1'b1;
        ifid_instr = NOP_INSTR;
        ifid_pc    = pc_inc;

        if (br_taken) begin
            pc_en  = 1'b1;
            pc_d   = br_target;
            hold_d = NOP_INSTR;
            if ((active && !imem_valid) || (state == ST_DROP)) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_RUN;
            end
        end else if (stall) begin
            ifid_wen = 1'b0;
            if (active && imem_valid) begin
                hold_d  = imem_instr;
                state_d = ST_HOLD;
            end else if ((state == ST_DROP) && imem_valid) begin
                state_d = ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN, ST_WAIT, ST_HOLD: begin
                    if (imem_valid || (state == ST_HOLD)) begin
                        ifid_instr = acc_instr;
                        pc_en      = 1'b1;
                        hold_d     = NOP_INSTR;
                        if (acc_instr[PC_W-1 -: OPC_W] == HLT_OPC) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_valid) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_MISS_CNT_EN
    // Saturating count of cycles lost to outstanding or discarded fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cycles <= '0;
        end else if (((state == ST_WAIT) || (state == ST_DROP)) && (miss_cycles != '1)) begin
            miss_cycles <= MISS_W'(miss_cycles + MISS_W'(1));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand sequences for reset-in-WAIT and PC wrap.
// Build with FETCH_MISS_CNT_EN defined to also cover miss_cycles.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_instr;
    logic        ifid_wen;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] pc;
    logic        halted;
`ifdef FETCH_MISS_CNT_EN
    logic [15:0] miss_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .ifid_wen   (ifid_wen),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .pc         (pc),
        .halted     (halted)
`ifdef FETCH_MISS_CNT_EN
        ,
        .miss_cycles(miss_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        v;
        logic [15:0] instr;
        logic        e_req;
        logic [15:0] e_pc;
        logic        e_wen;
        logic [15:0] e_iinstr;
        logic [15:0] e_ipc;
        logic        e_halt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        //            stall br  tgt       v   instr     req pc        wen iinstr    ipc       halt
        // normal hits at pc 0,2
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA000, 1'b1, 16'h0000, 1'b1, 16'hA000, 16'h0002, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA002, 1'b1, 16'h0002, 1'b1, 16'hA002, 16'h0004, 1'b0};
        // 3-cycle miss at pc 4
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA004, 1'b1, 16'h0004, 1'b1, 16'hA004, 16'h0006, 1'b0};
        // miss, response lands during stall -> HOLD, released after stall
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hA006, 1'b1, 16'h0006, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hA006, 16'h0008, 1'b0};
        // branch during miss -> DROP, late response discarded
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA008, 1'b0, 16'h0040, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA040, 1'b1, 16'h0040, 1'b1, 16'hA040, 16'h0042, 1'b0};
        // branch with response present -> RUN at 0x10, HLT fetched, then branch out of HALT
        vecs[14] = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'hA042, 1'b1, 16'h0042, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 1'b1, 16'h0010, 1'b1, 16'hF000, 16'h0012, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0012, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA012, 1'b0, 16'h0012, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0012, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA020, 1'b1, 16'h0020, 1'b1, 16'hA020, 16'h0022, 1'b0};
        // branch in DROP stays DROP; odd target passed through
        vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0022, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000, 1'b1, 16'h0022, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 16'h0031, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA111, 1'b0, 16'h0031, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA031, 1'b1, 16'h0031, 1'b1, 16'hA031, 16'h0033, 1'b0};

        rst_n      = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 16'h0000;
        imem_valid = 1'b0;
        imem_instr = 16'h0000;

        #3;
        chk("reset_pc", 32'(pc), 32'h0000);
        chk("reset_halted", 32'(halted), 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall      = vecs[i].stall;
            br_taken   = vecs[i].br;
            br_target  = vecs[i].tgt;
            imem_valid = vecs[i].v;
            imem_instr = vecs[i].instr;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_wen", i), 32'(ifid_wen), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_pc));
            end
            if (vecs[i].e_wen) begin
                chk($sformatf("v%0d_ifid_instr", i), 32'(ifid_instr), 32'(vecs[i].e_iinstr));
                if (vecs[i].e_iinstr != 16'h0000) begin
                    chk($sformatf("v%0d_ifid_pc", i), 32'(ifid_pc), 32'(vecs[i].e_ipc));
                end
            end
            @(posedge clk);
            #1;
        end

        // reset asserted while a miss is outstanding
        stall      = 1'b0;
        br_taken   = 1'b0;
        imem_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wait_pc_before_reset", 32'(pc), 32'h0033);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_pc", 32'(pc), 32'h0000);
        chk("midwait_reset_halted", 32'(halted), 32'h0);
        chk("midwait_reset_req", 32'(imem_req), 32'h1);
`ifdef FETCH_MISS_CNT_EN
        chk("midwait_reset_miss_cycles", 32'(miss_cycles), 32'h0);
`endif

        // PC wrap at 0xFFFE
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        br_taken   = 1'b1;
        br_target  = 16'hFFFE;
        imem_valid = 1'b1;
        imem_instr = 16'hA000;
        @(posedge clk);
        #1;
        br_taken   = 1'b0;
        imem_instr = 16'hB123;
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'hFFFE);
        chk("wrap_ifid_instr", 32'(ifid_instr), 32'hB123);
        chk("wrap_ifid_pc", 32'(ifid_pc), 32'h0000);
        @(posedge clk);
        #1;
        chk("wrap_pc_after", 32'(pc), 32'h0000);
        imem_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
